// File: rtl/conv_window_gen.sv
// conv_window_gen: buffers a row-major pixel stream in a 6-line ring and presents
// 5x5 windows (five columns of five stacked pixels) on a fixed SLOT-cycle grid.
//
//   state | meaning
//   ------+------------------------------------------------------------------
//   FILL  | after reset: accept pixels until the first 5 lines are complete
//   START | load window (0,0), raise x_valid, open the slot grid
//   RUN   | walk windows c=0..IMG_W-1, rows r=0..IMG_H-5, one per slot
//   END   | frame drained: grid keeps running with zero windows until the
//         | next frame has 5 complete lines, then re-enter RUN on a boundary
module conv_window_gen #(
   parameter int IMG_W = 32,
   parameter int IMG_H = 32,
   parameter int DW    = 9,
   parameter int SLOT  = 7
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [DW-1:0]   pix_in,
   input  logic            pix_valid,
   output logic            pix_ready,
   output logic            x_valid,
   output logic [5*DW-1:0] x_m_1,
   output logic [5*DW-1:0] x_m_2,
   output logic [5*DW-1:0] x_m_3,
   output logic [5*DW-1:0] x_m_4,
   output logic [5*DW-1:0] x_m_5,
   output logic            frame_done,
   output logic            underrun
);

   localparam int CW = $clog2(IMG_W);
   localparam int RW = $clog2(IMG_H);
   localparam int SW = $clog2(SLOT);
   localparam int NL = 6;

   typedef enum logic [1:0] {S_FILL, S_START, S_RUN, S_END} state_t;

   logic [DW-1:0]     mem_q [NL][IMG_W];
   logic [CW-1:0]     in_col_q;
   logic [2:0]        wr_ptr_q;
   logic [2:0]        rd_ptr_q, rd_ptr_d;
   // occ = complete lines not yet released; goes negative if the output side
   // releases rows the source never delivered (underrun), keeping the ring
   // pointers aligned as wr_ptr == rd_ptr + occ (mod 6).
   logic signed [7:0] occ_q, occ_d, rel;
   state_t            state_q, state_d;
   logic [SW-1:0]     slot_q, slot_d;
   logic [RW-1:0]     r_q, r_d;
   logic [CW-1:0]     c_q, c_d;
   logic              row_bad_q, row_bad_d;
   logic              underrun_q, underrun_d;
   logic              x_valid_q, x_valid_d;
   logic              frame_done_q, frame_done_d;
   logic [5*DW-1:0]   xm_q [5];
   logic [5*DW-1:0]   win [5];
   logic              load, load_zero;
   logic [2:0]        win_top;
   logic [CW-1:0]     win_col;
   logic              accept, line_done, slot_last;

   function automatic logic [2:0] ptr_add(input logic [2:0] p, input logic [2:0] k);
      logic [3:0] s;
      s = {1'b0, p} + {1'b0, k};
      if (s >= 4'd6) s = s - 4'd6;
      return s[2:0];
   endfunction

   assign pix_ready = ~rst & (occ_q < 8'sd6);
   assign accept    = pix_valid & pix_ready;
   assign line_done = accept & (in_col_q == CW'(IMG_W - 1));
   assign slot_last = (slot_q == SW'(SLOT - 1));

   // Line storage write; pointers alone define which lines are valid.
   always_ff @(posedge clk) begin
      if (accept) mem_q[wr_ptr_q][in_col_q] <= pix_in;
   end

   // Input side: column counter, write line pointer, occupancy.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         in_col_q <= '0;
         wr_ptr_q <= '0;
         occ_q    <= '0;
      end else begin
         occ_q <= occ_d;
         if (accept) begin
            if (line_done) begin
               in_col_q <= '0;
               wr_ptr_q <= ptr_add(wr_ptr_q, 3'd1);
            end else begin
               in_col_q <= in_col_q + CW'(1);
            end
         end
      end
   end

   // Window gather: rows win_top..+4, columns win_col..+4, zero past the right edge.
   always_comb begin
      for (int j = 0; j < 5; j++) begin
         win[j] = '0;
         for (int k = 0; k < 5; k++) begin
            if (int'(win_col) + j < IMG_W)
               win[j][(4-k)*DW +: DW] = mem_q[ptr_add(win_top, 3'(k))][win_col + CW'(j)];
         end
      end
   end

   // Next-state, slot grid, window position and ring release.
   always_comb begin
      state_d      = state_q;
      slot_d       = slot_q;
      r_d          = r_q;
      c_d          = c_q;
      rd_ptr_d     = rd_ptr_q;
      row_bad_d    = row_bad_q;
      underrun_d   = underrun_q;
      x_valid_d    = 1'b0;
      frame_done_d = 1'b0;
      load         = 1'b0;
      load_zero    = 1'b0;
      win_top      = rd_ptr_q;
      win_col      = c_q;
      rel          = 8'sd0;
      case (state_q)
         S_FILL: begin
            if (occ_q >= 8'sd5) state_d = S_START;
         end
         S_START: begin
            load      = 1'b1;
            win_col   = '0;
            x_valid_d = 1'b1;
            slot_d    = '0;
            r_d       = '0;
            c_d       = '0;
            row_bad_d = 1'b0;
            state_d   = S_RUN;
         end
         S_RUN: begin
            slot_d = slot_last ? '0 : slot_q + SW'(1);
            if (slot_q == SW'(SLOT - 2) && r_q == RW'(IMG_H - 5) && c_q == CW'(IMG_W - 1))
               frame_done_d = 1'b1;
            if (slot_last) begin
               load = 1'b1;
               if (c_q == CW'(IMG_W - 1)) begin
                  c_d = '0;
                  if (r_q == RW'(IMG_H - 5)) begin
                     // last row of the frame: drop all five held lines
                     rel       = 8'sd5;
                     rd_ptr_d  = ptr_add(rd_ptr_q, 3'd5);
                     load_zero = 1'b1;
                     state_d   = S_END;
                  end else begin
                     // next row needs old rows r+1..r+5 complete, i.e. 6 held now
                     rel        = 8'sd1;
                     rd_ptr_d   = ptr_add(rd_ptr_q, 3'd1);
                     r_d        = r_q + RW'(1);
                     win_top    = ptr_add(rd_ptr_q, 3'd1);
                     win_col    = '0;
                     row_bad_d  = (occ_q < 8'sd6);
                     underrun_d = underrun_q | (occ_q < 8'sd6);
                     load_zero  = (occ_q < 8'sd6);
                  end
               end else begin
                  c_d       = c_q + CW'(1);
                  win_col   = c_q + CW'(1);
                  load_zero = row_bad_q;
               end
            end
         end
         S_END: begin
            slot_d = slot_last ? '0 : slot_q + SW'(1);
            if (slot_last) begin
               load = 1'b1;
               if (occ_q >= 8'sd5) begin
                  r_d       = '0;
                  c_d       = '0;
                  win_col   = '0;
                  row_bad_d = 1'b0;
                  state_d   = S_RUN;
               end else begin
                  load_zero = 1'b1;
               end
            end
         end
         default: state_d = S_FILL;
      endcase
      occ_d = occ_q + (line_done ? 8'sd1 : 8'sd0) - rel;
   end

   // Output-side registers; window regs only move on slot boundaries.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_FILL;
         slot_q       <= '0;
         r_q          <= '0;
         c_q          <= '0;
         rd_ptr_q     <= '0;
         row_bad_q    <= 1'b0;
         underrun_q   <= 1'b0;
         x_valid_q    <= 1'b0;
         frame_done_q <= 1'b0;
         for (int j = 0; j < 5; j++) xm_q[j] <= '0;
      end else begin
         state_q      <= state_d;
         slot_q       <= slot_d;
         r_q          <= r_d;
         c_q          <= c_d;
         rd_ptr_q     <= rd_ptr_d;
         row_bad_q    <= row_bad_d;
         underrun_q   <= underrun_d;
         x_valid_q    <= x_valid_d;
         frame_done_q <= frame_done_d;
         if (load) begin
            for (int j = 0; j < 5; j++) xm_q[j] <= load_zero ? '0 : win[j];
         end
      end
   end

   assign x_valid    = x_valid_q;
   assign frame_done = frame_done_q;
   assign underrun   = underrun_q;
   assign x_m_1      = xm_q[0];
   assign x_m_2      = xm_q[1];
   assign x_m_3      = xm_q[2];
   assign x_m_4      = xm_q[3];
   assign x_m_5      = xm_q[4];

endmodule

// File: tb/tb_conv_window_gen.sv
// Scoreboard bench for conv_window_gen: expected windows are computed from the
// frame image and queued when the frame is generated; a negedge monitor follows
// the slot grid and pops/compares each presented window.
module tb_conv_window_gen;
   localparam int IMG_W = 32;
   localparam int IMG_H = 32;
   localparam int DW    = 9;
   localparam int SLOT  = 7;
   localparam int NSLOT = (IMG_H - 4) * IMG_W;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [DW-1:0] pix_in = '0;
   logic pix_valid = 1'b0;
   logic pix_ready, x_valid, frame_done, underrun;
   logic [5*DW-1:0] x_m_1, x_m_2, x_m_3, x_m_4, x_m_5;

   conv_window_gen #(.IMG_W(IMG_W), .IMG_H(IMG_H), .DW(DW), .SLOT(SLOT)) dut (
      .clk(clk), .rst(rst), .pix_in(pix_in), .pix_valid(pix_valid), .pix_ready(pix_ready),
      .x_valid(x_valid), .x_m_1(x_m_1), .x_m_2(x_m_2), .x_m_3(x_m_3), .x_m_4(x_m_4),
      .x_m_5(x_m_5), .frame_done(frame_done), .underrun(underrun));

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   logic [224:0] exp_q[$];
   logic [DW-1:0] pix_q[$];
   int img [IMG_H][IMG_W];
   int acc_cnt = 0, xv_cnt = 0, fd_cnt = 0, xv_acc = 0, ready_low = 0;
   int ph = 0, fslot = 0;
   logic started = 1'b0, in_gap = 1'b0, abort = 1'b0;
   logic [224:0] cur, held, first_win;

   assign cur = {x_m_1, x_m_2, x_m_3, x_m_4, x_m_5};

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Window at output row r, slot c: column j holds image column c+j, rows r..r+4 top-down.
   function automatic logic [224:0] model_win(input int r, input int c);
      logic [224:0] w;
      logic [DW-1:0] p;
      w = '0;
      for (int j = 0; j < 5; j++)
         for (int k = 0; k < 5; k++)
            if (c + j < IMG_W) begin
               p = DW'(img[r+k][c+j]);
               w[(4-j)*45 + (4-k)*DW +: DW] = p;
            end
      return w;
   endfunction

   task automatic gen_frame(input bit ramp, input int bad_row);
      for (int r = 0; r < IMG_H; r++)
         for (int c = 0; c < IMG_W; c++) begin
            img[r][c] = ramp ? ((r * 32 + c) & 255) : int'($urandom_range(0, 511));
            pix_q.push_back(DW'(img[r][c]));
         end
      for (int r = 0; r < IMG_H - 4; r++)
         for (int c = 0; c < IMG_W; c++)
            exp_q.push_back((r == bad_row) ? 225'd0 : model_win(r, c));
   endtask

   task automatic drive(input int pct, input int stall_at, input int budget);
      int cyc = 0;
      int stall = 0;
      logic acc;
      while (pix_q.size() > 0 && !abort && cyc < budget) begin
         if (stall_at >= 0 && acc_cnt == stall_at && stall < 300) begin
            pix_valid = 1'b0;
            stall++;
         end else begin
            pix_valid = (pct >= 100) || ($urandom_range(0, 99) < pct);
         end
         pix_in = pix_q[0];
         @(negedge clk);
         acc = pix_valid & pix_ready;
         @(posedge clk);
         #1;
         cyc++;
         if (acc) begin
            void'(pix_q.pop_front());
            acc_cnt++;
         end
      end
      pix_valid = 1'b0;
      chk("drive_budget", cyc < budget, 1);
   endtask

   task automatic wait_fd(input int n, input int budget);
      int cyc = 0;
      while (fd_cnt < n && cyc < budget) begin
         @(posedge clk);
         cyc++;
      end
      #1;
      chk("frame_done_count", fd_cnt, n);
   endtask

   task automatic pop_cmp();
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL window_extra actual=%0h required=none", cur);
      end else begin
         chk($sformatf("window slot%0d", fslot), cur, exp_q.pop_front());
      end
   endtask

   // Monitor: follows the slot grid from the x_valid pulse.
   always @(negedge clk) begin
      logic exp_fd;
      if (rst) begin
         started = 1'b0; ph = 0; fslot = 0; in_gap = 1'b0; xv_cnt = 0; fd_cnt = 0;
      end else begin
         if (!pix_ready) ready_low++;
         if (x_valid) begin
            xv_cnt++;
            if (!started) begin
               started = 1'b1; ph = 0; fslot = 0; in_gap = 1'b0;
               xv_acc = acc_cnt;
               first_win = cur;
               pop_cmp();
               held = cur;
            end
         end else if (started) begin
            ph++;
            if (ph == SLOT) begin
               ph = 0;
               if (in_gap) begin
                  if (cur != '0) begin
                     in_gap = 1'b0;
                     fslot = 0;
                     pop_cmp();
                  end
               end else begin
                  fslot++;
                  pop_cmp();
               end
               held = cur;
            end else begin
               chk("window_hold", cur, held);
            end
         end
         exp_fd = started && !in_gap && fslot == NSLOT - 1 && ph == SLOT - 1;
         if (exp_fd || frame_done) chk("frame_done_pulse", frame_done, exp_fd);
         if (frame_done) fd_cnt++;
         if (exp_fd) in_gap = 1'b1;
      end
   end

   initial begin
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_outputs", {x_valid, frame_done, underrun, pix_ready, cur}, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("ready_after_reset", pix_ready, 1);
      chk("underrun_after_reset", underrun, 0);
      @(posedge clk); #1;

      // Two back-to-back random frames, source mostly ready.
      gen_frame(1'b0, -1);
      gen_frame(1'b0, -1);
      drive(80, -1, 20000);
      wait_fd(2, 12000);
      chk("queue_drained_2f", exp_q.size(), 0);
      chk("x_valid_once_2f", xv_cnt, 1);
      chk("x_valid_after_160_lo", xv_acc >= 160, 1);
      chk("x_valid_after_160_hi", xv_acc <= 163, 1);
      chk("no_underrun_2f", underrun, 0);
      chk("ready_backpressure", ready_low > 0, 1);
      chk("pixels_accepted_2f", acc_cnt, 2 * IMG_W * IMG_H);

      // Reset in the middle of output row 10.
      rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
      pix_q.delete(); exp_q.delete(); acc_cnt = 0;
      gen_frame(1'b0, -1);
      fork
         drive(100, -1, 20000);
         begin
            int cyc = 0;
            while (!(started && fslot >= 10 * IMG_W + 5) && cyc < 20000) begin
               @(posedge clk);
               cyc++;
            end
            #1;
            chk("reached_row10", cyc < 20000, 1);
            rst = 1'b1;
            abort = 1'b1;
         end
      join
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("mid_reset_outputs", {x_valid, frame_done, underrun, cur}, 0);
      chk("mid_reset_ready", pix_ready, 1);
      pix_q.delete(); exp_q.delete(); acc_cnt = 0; abort = 1'b0;
      @(posedge clk); #1;

      // Ramp frame, source stalls 300 cycles after five rows: row 1 underruns.
      gen_frame(1'b1, 1);
      drive(100, 160, 20000);
      wait_fd(1, 12000);
      chk("underrun_sticky", underrun, 1);
      chk("x_valid_fresh", xv_cnt, 1);
      chk("queue_drained_uf", exp_q.size(), 0);
      chk("ramp_first_xm1", first_win[224:180], {9'd0, 9'd32, 9'd64, 9'd96, 9'd128});
      chk("ramp_first_xm5_top", first_win[44:36], 9'd4);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
